// File: rtl/font_rom_pkg.sv
// font_rom_pkg: shared font ROM widths, address type and read tag type for the ROM arbiter and VGA controllers
package font_rom_pkg;
  localparam int FNT_W = 4;
  localparam int ADDR_SIZE = 7;
  typedef struct packed {
    logic v1;
    logic v0;
  } font_tag_t;
  typedef logic [ADDR_SIZE-1:0] font_addr_t;
endpackage

// File: rtl/font_rom_tag_pipe.sv
// font_rom_tag_pipe: DEPTH-stage shift register of read tags with async clear (clk, rst, tag_in -> tag_out)
module font_rom_tag_pipe
  import font_rom_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  font_tag_t tag_in,
  output font_tag_t tag_out
);
  font_tag_t [DEPTH-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else pipe_q <= pipe_d;
  end
  assign tag_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: two-requester font ROM arbiter (req/addr in, gnt/rvalid/rdata out per requester; rom_addr out, rom_q in)
module font_rom_arbiter
  import font_rom_pkg::*;
#(
  parameter int ADDR_SIZE  = font_rom_pkg::ADDR_SIZE,
  parameter int FNT_W      = font_rom_pkg::FNT_W,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [ADDR_SIZE-1:0] addr0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [FNT_W-1:0]     rdata0,
  input  logic                 req1,
  input  logic [ADDR_SIZE-1:0] addr1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [FNT_W-1:0]     rdata1,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [FNT_W-1:0]     rom_q
);
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  if (ROM_LAT < 1) begin : g_bad_lat
    $error("ROM_LAT must be at least 1");
  end
  logic [SW-1:0] starve_q, starve_d;
  logic [ADDR_SIZE-1:0] last_addr_q, last_addr_d;
  logic force1;
  font_tag_t tag_in, tag_out;
  always_comb begin
    force1 = (STARVE_MAX != 0) && (starve_q == SMAX);
    gnt1 = !rst && req1 && (!req0 || force1);
    gnt0 = !rst && req0 && !gnt1;
    rom_addr = gnt0 ? addr0 : gnt1 ? addr1 : last_addr_q;
    last_addr_d = rom_addr;
    starve_d = (!req1 || gnt1) ? '0 : (starve_q == SMAX) ? starve_q : starve_q + 1'b1;
    tag_in = '{v1: gnt1, v0: gnt0};
    rvalid0 = tag_out.v0;
    rvalid1 = tag_out.v1;
    rdata0 = rvalid0 ? rom_q : '0;
    rdata1 = rvalid1 ? rom_q : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      last_addr_q <= '0;
    end else begin
      starve_q <= starve_d;
      last_addr_q <= last_addr_d;
    end
  end
  font_rom_tag_pipe #(.DEPTH(ROM_LAT)) u_tag_pipe (
    .clk(clk),
    .rst(rst),
    .tag_in(tag_in),
    .tag_out(tag_out)
  );
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: two arbiter configurations driven in parallel and checked against a cycle-level reference model
module tb_font_rom_arbiter;
  localparam int AW = 7;
  localparam int FW = 4;
  localparam int LAT_A = 1;
  localparam int SM_A = 4;
  localparam int LAT_B = 2;
  localparam int SM_B = 0;
  localparam int NCYC = 2048;
  logic clk = 0;
  logic rst = 1;
  logic req0 = 0;
  logic req1 = 0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic gnt0_a, gnt1_a, rv0_a, rv1_a;
  logic gnt0_b, gnt1_b, rv0_b, rv1_b;
  logic [FW-1:0] rd0_a, rd1_a, romq_a, rd0_b, rd1_b, romq_b, romp_b;
  logic [AW-1:0] ra_a, ra_b;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int starve_m [2];
  logic [AW-1:0] last_m [2];
  bit ev0 [2][NCYC];
  bit ev1 [2][NCYC];
  logic [FW-1:0] ed [2][NCYC];

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] rom_fn(input logic [AW-1:0] a);
    return FW'(32'(a) * 7 + 32'(a) / 8 + 1);
  endfunction

  always @(posedge clk) romq_a <= rom_fn(ra_a);
  always @(posedge clk) begin
    romp_b <= rom_fn(ra_b);
    romq_b <= romp_b;
  end

  font_rom_arbiter #(.ADDR_SIZE(AW), .FNT_W(FW), .ROM_LAT(LAT_A), .STARVE_MAX(SM_A)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rv0_a), .rdata0(rd0_a),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .rvalid1(rv1_a), .rdata1(rd1_a),
    .rom_addr(ra_a), .rom_q(romq_a)
  );

  font_rom_arbiter #(.ADDR_SIZE(AW), .FNT_W(FW), .ROM_LAT(LAT_B), .STARVE_MAX(SM_B)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rv0_b), .rdata0(rd0_b),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .rvalid1(rv1_b), .rdata1(rd1_b),
    .rom_addr(ra_b), .rom_q(romq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Requester 1 is forced through once it has lost sm consecutive cycles; reads come back lat cycles later.
  task automatic check_inst(input int k, input int sm, input int lat, input string p,
                            input logic g0, input logic g1, input logic [AW-1:0] ra,
                            input logic v0, input logic v1, input logic [FW-1:0] d0, input logic [FW-1:0] d1);
    bit e0, e1, f, x0, x1;
    logic [AW-1:0] ea;
    e0 = 0;
    e1 = 0;
    ea = '0;
    if (!rst) begin
      f = sm != 0 && starve_m[k] == sm;
      e1 = req1 && (!req0 || f);
      e0 = req0 && !e1;
      ea = e0 ? addr0 : e1 ? addr1 : last_m[k];
    end
    x0 = !rst && ev0[k][cyc];
    x1 = !rst && ev1[k][cyc];
    chk({p, ".gnt0"}, 32'(g0), 32'(e0));
    chk({p, ".gnt1"}, 32'(g1), 32'(e1));
    chk({p, ".rom_addr"}, 32'(ra), 32'(ea));
    chk({p, ".rvalid0"}, 32'(v0), 32'(x0));
    chk({p, ".rvalid1"}, 32'(v1), 32'(x1));
    chk({p, ".rdata0"}, 32'(d0), x0 ? 32'(ed[k][cyc]) : 32'd0);
    chk({p, ".rdata1"}, 32'(d1), x1 ? 32'(ed[k][cyc]) : 32'd0);
    if (rst) begin
      starve_m[k] = 0;
      last_m[k] = '0;
      for (int i = cyc + 1; i < NCYC; i++) begin
        ev0[k][i] = 0;
        ev1[k][i] = 0;
      end
    end else begin
      starve_m[k] = (!req1 || e1) ? 0 : (starve_m[k] < sm ? starve_m[k] + 1 : sm);
      if (e0 || e1) begin
        last_m[k] = ea;
        ev0[k][cyc + lat] = e0;
        ev1[k][cyc + lat] = e1;
        ed[k][cyc + lat] = rom_fn(ea);
      end
    end
  endtask

  task automatic step();
    #2;
    check_inst(0, SM_A, LAT_A, "a", gnt0_a, gnt1_a, ra_a, rv0_a, rv1_a, rd0_a, rd1_a);
    check_inst(1, SM_B, LAT_B, "b", gnt0_b, gnt1_b, ra_b, rv0_b, rv1_b, rd0_b, rd1_b);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= NCYC - 4) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, NCYC - 4);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  initial begin
    int g1_a;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 0;
    step();
    req0 = 1;
    for (int i = 0; i < 16; i++) begin
      addr0 = AW'(i);
      step();
    end
    req0 = 0;
    step();
    addr0 = 7'h11;
    addr1 = 7'h22;
    req0 = 1;
    req1 = 1;
    g1_a = 0;
    for (int i = 0; i < 100; i++) begin
      if (gnt1_a) g1_a++;
      step();
    end
    chk("a.fair_count", 32'(g1_a), 32'd20);
    req0 = 0;
    step();
    step();
    req1 = 0;
    step();
    addr1 = 7'h25;
    req1 = 1;
    step();
    req1 = 0;
    addr1 = 7'h4a;
    repeat (5) step();
    addr0 = 7'h33;
    addr1 = 7'h33;
    req0 = 1;
    req1 = 1;
    repeat (12) step();
    req1 = 0;
    addr0 = 7'h01;
    step();
    addr0 = 7'h02;
    rst = 1;
    step();
    step();
    rst = 0;
    addr0 = 7'h03;
    repeat (4) step();
    repeat (400) begin
      rst = $urandom_range(0, 49) == 0;
      req0 = $urandom_range(0, 3) != 0;
      req1 = $urandom_range(0, 3) != 0;
      addr0 = AW'($urandom_range(0, 127));
      addr1 = AW'($urandom_range(0, 127));
      step();
    end
    rst = 0;
    req0 = 0;
    req1 = 0;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
